// File: rtl/jt12_slot_sched.sv
// Slot sequencer and single-entry write scheduler for the 24-stage per-slot ring.
// A write waits for its target channel/operator slot, then steers one word into the ring input.
module jt12_slot_sched #(
    parameter int DW    = 8,
    parameter int SLOTS = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          wr_req,
    input  logic [2:0]    wr_ch,
    input  logic [1:0]    wr_op,
    input  logic [DW-1:0] wr_data,
    output logic          wr_busy,
    output logic          wr_ack,
    output logic          wr_err,
    output logic [4:0]    slot,
    output logic [2:0]    cur_ch,
    output logic [1:0]    cur_op,
    output logic          zero,
    output logic          ring_we,
    output logic [DW-1:0] ring_din
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);
    localparam logic [2:0] LAST_CH   = 3'd5;

    state_t     state, state_nx;
    logic [2:0] tgt_ch;
    logic [1:0] tgt_op;
    logic       err_flag;
    logic       req_ok;
    logic       slot_hit;

    // Slot counter: channel is the fast index, operator the slow one.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch <= 3'd0;
            cur_op <= 2'd0;
            slot   <= 5'd0;
        end else if (cen) begin
            if (cur_ch == LAST_CH) begin
                cur_ch <= 3'd0;
                cur_op <= cur_op + 2'd1;
            end else begin
                cur_ch <= cur_ch + 3'd1;
            end
            slot <= (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
        end
    end

    assign zero     = (slot == 5'd0);
    assign req_ok   = (wr_ch <= LAST_CH);
    assign slot_hit = (cur_ch == tgt_ch) && (cur_op == tgt_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: next state gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (wr_req) state_nx = req_ok ? WAIT : DONE;
            WAIT: if (ring_we) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request capture; ring_din doubles as the latched data and holds between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_ch   <= 3'd0;
            tgt_op   <= 2'd0;
            err_flag <= 1'b0;
            ring_din <= '0;
        end else if (state == IDLE && wr_req) begin
            err_flag <= !req_ok;
            if (req_ok) begin
                tgt_ch   <= wr_ch;
                tgt_op   <= wr_op;
                ring_din <= wr_data;
            end
        end
    end

    assign ring_we = (state == WAIT) && cen && slot_hit;
    assign wr_busy = (state == WAIT);
    assign wr_ack  = (state == DONE);
    assign wr_err  = (state == DONE) && err_flag;

endmodule

// File: tb/tb_jt12_slot_sched.sv
// Directed bench for jt12_slot_sched: slot counting, write scheduling, cen gaps, errors and reset.
module tb_jt12_slot_sched;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          cen;
    logic          wr_req;
    logic [2:0]    wr_ch;
    logic [1:0]    wr_op;
    logic [DW-1:0] wr_data;
    logic          wr_busy;
    logic          wr_ack;
    logic          wr_err;
    logic [4:0]    slot;
    logic [2:0]    cur_ch;
    logic [1:0]    cur_op;
    logic          zero;
    logic          ring_we;
    logic [DW-1:0] ring_din;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_slot = 0;
    int we_cnt   = 0;
    int ack_cnt  = 0;

    jt12_slot_sched #(.DW(DW), .SLOTS(24)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .wr_req   (wr_req),
        .wr_ch    (wr_ch),
        .wr_op    (wr_op),
        .wr_data  (wr_data),
        .wr_busy  (wr_busy),
        .wr_ack   (wr_ack),
        .wr_err   (wr_err),
        .slot     (slot),
        .cur_ch   (cur_ch),
        .cur_op   (cur_op),
        .zero     (zero),
        .ring_we  (ring_we),
        .ring_din (ring_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ring_we) we_cnt <= we_cnt + 1;
        if (wr_ack)  ack_cnt <= ack_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; the slot model follows only edges that saw cen=1.
    task automatic step();
        logic c;
        c = cen;
        @(negedge clk);
        if (c) exp_slot = (exp_slot == 23) ? 0 : exp_slot + 1;
    endtask

    task automatic goto_slot(input int s);
        int n;
        n = 0;
        cen = 1'b1;
        while (exp_slot != s && n < 30) begin
            step();
            n++;
        end
        check("goto_slot", slot, s);
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (!wr_ack && n < 40) begin
            step();
            n++;
        end
        check("ack_seen", wr_ack, 1);
    endtask

    initial begin
        int cycles;
        int we0;
        int ack0;

        rst_n = 1'b0; cen = 1'b0; wr_req = 1'b0;
        wr_ch = 3'd0; wr_op = 2'd0; wr_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_slot", slot, 0);
        check("rst_ch", cur_ch, 0);
        check("rst_op", cur_op, 0);
        check("rst_zero", zero, 1);
        check("rst_busy", wr_busy, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_err", wr_err, 0);
        check("rst_we", ring_we, 0);
        check("rst_din", ring_din, 0);

        // Free-running count over two full frames
        rst_n = 1'b1; cen = 1'b1; exp_slot = 0;
        for (int i = 0; i < 48; i++) begin
            check("cnt_slot", slot, exp_slot);
            check("cnt_zero", zero, (i % 24) == 0);
            check("cnt_ch", cur_ch, exp_slot % 6);
            check("cnt_op", cur_op, exp_slot / 6);
            if (i == 13) begin
                check("s13_ch", cur_ch, 1);
                check("s13_op", cur_op, 2);
            end
            step();
        end

        // Write ch=3 op=1 issued at slot 0 lands at slot 9
        goto_slot(0);
        we0 = we_cnt; ack0 = ack_cnt;
        wr_req = 1'b1; wr_ch = 3'd3; wr_op = 2'd1; wr_data = 8'hA5;
        step();
        wr_req = 1'b0;
        check("w1_busy", wr_busy, 1);
        while (exp_slot != 9) step();
        check("w1_slot", slot, 9);
        check("w1_we", ring_we, 1);
        check("w1_din", ring_din, 8'hA5);
        step();
        check("w1_ack", wr_ack, 1);
        check("w1_err", wr_err, 0);
        check("w1_busy_done", wr_busy, 0);
        check("w1_we_done", ring_we, 0);
        step();
        check("w1_ack_drop", wr_ack, 0);
        check("w1_we_count", we_cnt - we0, 1);
        check("w1_ack_count", ack_cnt - ack0, 1);

        // cen gap in the match cycle, then cen toggling
        goto_slot(2);
        wr_req = 1'b1; wr_ch = 3'd4; wr_op = 2'd0; wr_data = 8'h5A;
        step();
        wr_req = 1'b0;
        step();
        check("cg_slot4", slot, 4);
        cen = 1'b0;
        #1;
        check("cg_we_gated", ring_we, 0);
        step();
        check("cg_slot_hold", slot, 4);
        check("cg_busy", wr_busy, 1);
        cen = 1'b1;
        #1;
        check("cg_we", ring_we, 1);
        check("cg_din", ring_din, 8'h5A);
        step();
        check("cg_ack", wr_ack, 1);
        check("cg_slot5", slot, 5);
        cen = 1'b0; step();
        check("tg_hold5", slot, 5);
        cen = 1'b1; step();
        check("tg_adv6", slot, 6);
        cen = 1'b0; step();
        check("tg_hold6", slot, 6);
        cen = 1'b1; step();
        check("tg_adv7", slot, 7);

        // Target equals current slot: written on the next visit, 24 clocks later
        goto_slot(5);
        we0 = we_cnt;
        wr_req = 1'b1; wr_ch = 3'd5; wr_op = 2'd0; wr_data = 8'hC3;
        step();
        wr_req = 1'b0;
        cycles = 1;
        while (!ring_we && cycles < 40) begin
            step();
            cycles++;
        end
        check("cur_latency", cycles, 24);
        check("cur_slot", slot, 5);
        check("cur_din", ring_din, 8'hC3);
        step();
        check("cur_ack", wr_ack, 1);
        check("cur_we_count", we_cnt - we0, 1);

        // Invalid channel: immediate error ack, no ring write
        step();
        we0 = we_cnt; ack0 = ack_cnt;
        wr_req = 1'b1; wr_ch = 3'd7; wr_op = 2'd0; wr_data = 8'hEE;
        step();
        wr_req = 1'b0;
        check("err_ack", wr_ack, 1);
        check("err_flag", wr_err, 1);
        check("err_busy", wr_busy, 0);
        step();
        check("err_ack_drop", wr_ack, 0);
        check("err_flag_drop", wr_err, 0);
        check("err_we_count", we_cnt - we0, 0);
        check("err_din_kept", ring_din, 8'hC3);

        // Second request while busy is ignored
        goto_slot(10);
        we0 = we_cnt; ack0 = ack_cnt;
        wr_req = 1'b1; wr_ch = 3'd0; wr_op = 2'd0; wr_data = 8'h3C;
        step();
        wr_ch = 3'd1; wr_op = 2'd3; wr_data = 8'h77;
        repeat (3) step();
        wr_req = 1'b0;
        check("busy_still", wr_busy, 1);
        wait_ack();
        repeat (3) step();
        check("busy_we_count", we_cnt - we0, 1);
        check("busy_ack_count", ack_cnt - ack0, 1);
        check("busy_din", ring_din, 8'h3C);

        // Asynchronous reset while a write is pending
        goto_slot(1);
        we0 = we_cnt; ack0 = ack_cnt;
        wr_req = 1'b1; wr_ch = 3'd2; wr_op = 2'd3; wr_data = 8'h99;
        step();
        wr_req = 1'b0;
        repeat (3) step();
        check("rm_busy_before", wr_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rm_slot", slot, 0);
        check("rm_busy", wr_busy, 0);
        check("rm_zero", zero, 1);
        check("rm_we", ring_we, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; exp_slot = 0;
        for (int i = 0; i < 30; i++) step();
        check("rm_slot_resume", slot, 30 % 24);
        check("rm_no_ack", ack_cnt - ack0, 0);
        check("rm_no_we", we_cnt - we0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
